// File: rtl/imm_gen_pipe_pkg.sv
// +--------------------------------------------------------------------------+
// | imm_gen_pipe_pkg                                                         |
// | Shared immediate-select encodings, default width and skid state type.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package imm_gen_pipe_pkg;

  localparam int unsigned c_xlen_default = 32;

  localparam logic [2:0] c_sel_i = 3'd0;
  localparam logic [2:0] c_sel_s = 3'd1;
  localparam logic [2:0] c_sel_b = 3'd2;
  localparam logic [2:0] c_sel_j = 3'd3;
  localparam logic [2:0] c_sel_u = 3'd4;
  localparam logic [2:0] c_sel_z = 3'd5;

  // Bit 0 = main register valid, bit 1 = skid register valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/imm_gen_pipe_imm_decode.sv
// +--------------------------------------------------------------------------+
// | imm_decode                                                               |
// | Combinational RISC-V immediate extraction and extension to XLEN.        |
// | Optional CSR zimm format enabled by macro IMMGEN_ZIMM_EN.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = c_xlen_default
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm,
  output logic            sel_err
);

  logic [11:0] w_imm_i;
  logic [11:0] w_imm_s;
  logic [12:0] w_imm_b;
  logic [20:0] w_imm_j;
  logic [31:0] w_imm_u;
  logic        w_unused_opcode;

  assign w_imm_i = inst[31:20];
  assign w_imm_s = {inst[31:25], inst[11:7]};
  assign w_imm_b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign w_imm_j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign w_imm_u = {inst[31:12], 12'b0};

  // Opcode bits never contribute to an immediate.
  assign w_unused_opcode = ^inst[6:0];

  always_comb begin
    imm     = '0;
    sel_err = 1'b0;
    case (sel)
      c_sel_i: imm = XLEN'($signed(w_imm_i));
      c_sel_s: imm = XLEN'($signed(w_imm_s));
      c_sel_b: imm = XLEN'($signed(w_imm_b));
      c_sel_j: imm = XLEN'($signed(w_imm_j));
      c_sel_u: imm = XLEN'($signed(w_imm_u));
`ifdef IMMGEN_ZIMM_EN
      c_sel_z: imm = XLEN'(inst[19:15]);
`endif
      default: begin
        imm     = '0;
        sel_err = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// +--------------------------------------------------------------------------+
// | imm_gen_pipe                                                             |
// | Pipelined immediate generator with 2-entry skid buffer and error count. |
// | Optional CSR zimm format enabled by macro IMMGEN_ZIMM_EN.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = c_xlen_default,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_sel_err,
  output logic [15:0]      err_cnt
);

  logic [XLEN-1:0]  w_imm;
  logic             w_sel_err;
  logic             w_accept;
  logic             w_drain;

  skid_state_t      r_state;
  logic [XLEN-1:0]  r_skid_imm;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_skid_err;

  imm_decode #(
    .XLEN (XLEN)
  ) u_imm_decode (
    .inst    (in_inst),
    .sel     (in_imm_sel),
    .imm     (w_imm),
    .sel_err (w_sel_err)
  );

  assign out_valid = r_state[0];
  assign w_accept  = in_valid & in_ready;
  assign w_drain   = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      in_ready    <= 1'b1;
      out_imm     <= '0;
      out_tag     <= '0;
      out_sel_err <= 1'b0;
      r_skid_imm  <= '0;
      r_skid_tag  <= '0;
      r_skid_err  <= 1'b0;
      err_cnt     <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            out_imm     <= w_imm;
            out_tag     <= in_tag;
            out_sel_err <= w_sel_err;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            out_imm     <= w_imm;
            out_tag     <= in_tag;
            out_sel_err <= w_sel_err;
          end else if (w_accept) begin
            // Main is stalled: park the newcomer and close the input.
            r_skid_imm <= w_imm;
            r_skid_tag <= in_tag;
            r_skid_err <= w_sel_err;
            r_state    <= ST_FULL;
            in_ready   <= 1'b0;
          end else if (w_drain) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            out_imm     <= r_skid_imm;
            out_tag     <= r_skid_tag;
            out_sel_err <= r_skid_err;
            r_state     <= ST_ONE;
            in_ready    <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_EMPTY;
          in_ready <= 1'b1;
        end
      endcase

      if (w_accept && w_sel_err && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// +--------------------------------------------------------------------------+
// | tb_imm_gen_pipe                                                          |
// | Directed self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64).     |
// | Expectations follow macro IMMGEN_ZIMM_EN.                                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_imm_gen_pipe;
  import imm_gen_pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [2:0]  in_imm_sel;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [7:0]  out_tag;
  logic        out_sel_err;
  logic [15:0] err_cnt;

  logic        u_in_valid;
  logic        u_in_ready;
  logic [31:0] u_in_inst;
  logic [2:0]  u_in_imm_sel;
  logic [7:0]  u_in_tag;
  logic        u_out_valid;
  logic [63:0] u_out_imm;
  logic [7:0]  u_out_tag;
  logic        u_out_sel_err;
  logic [15:0] u_err_cnt;

  int n_cmp;
  int n_bad;
  int exp_errs;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready), .in_inst (in_inst),
    .in_imm_sel (in_imm_sel), .in_tag (in_tag),
    .out_valid (out_valid), .out_ready (out_ready), .out_imm (out_imm),
    .out_tag (out_tag), .out_sel_err (out_sel_err), .err_cnt (err_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk (clk), .rst (rst),
    .in_valid (u_in_valid), .in_ready (u_in_ready), .in_inst (u_in_inst),
    .in_imm_sel (u_in_imm_sel), .in_tag (u_in_tag),
    .out_valid (u_out_valid), .out_ready (1'b1), .out_imm (u_out_imm),
    .out_tag (u_out_tag), .out_sel_err (u_out_sel_err), .err_cnt (u_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one entry with out_ready=1, check the result one cycle later.
  task automatic send_one(input string name, input logic [31:0] inst, input logic [2:0] sel,
                          input logic [7:0] tag, input logic [31:0] exp_imm, input logic exp_err);
    in_valid   = 1'b1;
    in_inst    = inst;
    in_imm_sel = sel;
    in_tag     = tag;
    @(negedge clk);
    in_valid = 1'b0;
    check_val({name, "_valid"}, 64'(out_valid), 64'd1);
    check_val({name, "_imm"}, 64'(out_imm), 64'(exp_imm));
    check_val({name, "_tag"}, 64'(out_tag), 64'(tag));
    check_val({name, "_err"}, 64'(out_sel_err), 64'(exp_err));
    check_val({name, "_rdy"}, 64'(in_ready), 64'd1);
    @(negedge clk);
  endtask

  task automatic send_u64(input string name, input logic [31:0] inst, input logic [63:0] exp_imm);
    u_in_valid   = 1'b1;
    u_in_inst    = inst;
    u_in_imm_sel = c_sel_u;
    u_in_tag     = 8'h64;
    @(negedge clk);
    u_in_valid = 1'b0;
    check_val({name, "_valid"}, 64'(u_out_valid), 64'd1);
    check_val({name, "_imm"}, u_out_imm, exp_imm);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; exp_errs = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_inst = '0; in_imm_sel = '0; in_tag = '0; out_ready = 1'b1;
    u_in_valid = 1'b0; u_in_inst = '0; u_in_imm_sel = '0; u_in_tag = '0;
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_imm", 64'(out_imm), 64'd0);
    check_val("rst_out_tag", 64'(out_tag), 64'd0);
    check_val("rst_sel_err", 64'(out_sel_err), 64'd0);
    check_val("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    send_one("i_neg1", 32'hFFF00093, c_sel_i, 8'h11, 32'hFFFFFFFF, 1'b0);
    send_one("s_pos8", 32'h00A12423, c_sel_s, 8'h22, 32'h00000008, 1'b0);
    send_one("b_neg4", 32'hFE000EE3, c_sel_b, 8'h33, 32'hFFFFFFFC, 1'b0);
    send_one("j_pos8", 32'h0080006F, c_sel_j, 8'h44, 32'h00000008, 1'b0);
    send_one("u_32", 32'h80000037, c_sel_u, 8'h55, 32'h80000000, 1'b0);

    send_one("sel7", 32'h12345678, 3'd7, 8'h66, 32'h0, 1'b1);
    exp_errs++;
    check_val("sel7_cnt", 64'(err_cnt), 64'(exp_errs));
`ifdef IMMGEN_ZIMM_EN
    send_one("zimm", 32'h0002D073, c_sel_z, 8'h77, 32'h00000005, 1'b0);
`else
    send_one("zimm", 32'h0002D073, c_sel_z, 8'h77, 32'h0, 1'b1);
    exp_errs++;
`endif
    check_val("zimm_cnt", 64'(err_cnt), 64'(exp_errs));

    send_u64("u64_neg", 32'h80000037, 64'hFFFFFFFF80000000);
    send_u64("u64_pos", 32'h12345037, 64'h0000000012345000);

    // Back-to-back offers into a stalled output.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_imm_sel = c_sel_i; in_tag = 8'hA1;
    @(negedge clk);
    check_val("skid_rdy_one", 64'(in_ready), 64'd1);
    check_val("skid_a_imm", 64'(out_imm), 64'd1);
    in_inst = 32'h00A12423; in_imm_sel = c_sel_s; in_tag = 8'hB2;
    @(negedge clk);
    check_val("skid_rdy_full", 64'(in_ready), 64'd0);
    in_inst = 32'h7FF00093; in_imm_sel = c_sel_i; in_tag = 8'hC3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("stall_rdy", 64'(in_ready), 64'd0);
      check_val("stall_valid", 64'(out_valid), 64'd1);
      check_val("stall_imm", 64'(out_imm), 64'd1);
      check_val("stall_tag", 64'(out_tag), 64'hA1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_val("drain_b_imm", 64'(out_imm), 64'd8);
    check_val("drain_b_tag", 64'(out_tag), 64'hB2);
    check_val("drain_b_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_val("drain_c_imm", 64'(out_imm), 64'h7FF);
    check_val("drain_c_tag", 64'(out_tag), 64'hC3);
    @(negedge clk);
    check_val("drain_empty", 64'(out_valid), 64'd0);

    // Saturate the error counter with a continuous stream of illegal selects.
    in_valid = 1'b1; in_inst = 32'hDEADBEEF; in_imm_sel = 3'd7; in_tag = 8'hEE;
    repeat (65536) @(negedge clk);
    check_val("sat_cnt", 64'(err_cnt), 64'hFFFF);
    check_val("sat_err", 64'(out_sel_err), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_val("sat_hold", 64'(err_cnt), 64'hFFFF);
    @(negedge clk);

    // Asynchronous reset while both registers hold entries.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_imm_sel = c_sel_i; in_tag = 8'h01;
    @(negedge clk);
    in_tag = 8'h02;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("pre_rst_full", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    check_val("arst_valid", 64'(out_valid), 64'd0);
    check_val("arst_rdy", 64'(in_ready), 64'd1);
    check_val("arst_cnt", 64'(err_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    send_one("post_rst", 32'hFFF00093, c_sel_i, 8'h5A, 32'hFFFFFFFF, 1'b0);
    check_val("post_rst_empty", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
